sdp_rd_seq: RTL and testbench

SDP_RD_SEQ -- requirements
Module: sdp_rd_seq

---
 rtl/sdp_pkg.sv | 28 ++
 rtl/sdp_addr_cnt.sv | 50 +++++
 rtl/sdp_rd_seq.sv | 104 ++++++++++
 tb/tb_sdp_rd_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_pkg.sv
// Shared state encoding and field layout for the SDP read-address sequencer.
// Latency: none (types, constants and constant functions only).
// Backpressure: none.
package sdp_pkg;

  // Sequencer FSM encoding: IDLE accepts commands, BUSY issues beats.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sdp_state_e;

  // cmd_data = {cnt, base}: base sits at bit 0, cnt directly above it.
  localparam int CMD_BASE_LSB = 0;

  // addr_data = {eot, addr}: addr sits at bit 0, eot is the single MSB.
  localparam int ADDR_ADDR_LSB = 0;

  // Bit position of the cnt field inside cmd_data.
  function automatic int cmd_cnt_lsb(input int w_addr);
    return w_addr;
  endfunction

  // Bit position of the eot flag inside addr_data.
  function automatic int addr_eot_pos(input int w_addr);
    return w_addr;
  endfunction

endpackage

// File: rtl/sdp_addr_cnt.sv
// Loadable address counter with optional wrap at DEPTH (SDP_RD_SEQ_WRAP_EN).
// Latency: load or inc takes effect on the next rising edge of clk.
// Backpressure: none; the owner gates inc with its own beat handshake.
module sdp_addr_cnt
  import sdp_pkg::*;
#(
  parameter int W_ADDR = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [W_ADDR-1:0] load_val,
  input  logic              inc,
  output logic [W_ADDR-1:0] addr
);

  logic [W_ADDR-1:0] load_addr;
  logic [W_ADDR-1:0] next_addr;

`ifdef SDP_RD_SEQ_WRAP_EN
  // One extra bit so DEPTH == 2^W_ADDR is representable as a divisor.
  localparam logic [W_ADDR:0]   DEPTH_X = (W_ADDR + 1)'(DEPTH);
  localparam logic [W_ADDR-1:0] LAST    = W_ADDR'(DEPTH - 1);

  // Out-of-range bases fold into the memory; the last row wraps to row 0.
  always_comb begin
    load_addr = W_ADDR'({1'b0, load_val} % DEPTH_X);
    next_addr = (addr == LAST) ? '0 : addr + 1'b1;
  end
`else
  // Natural binary wrap at 2^W_ADDR.
  always_comb begin
    load_addr = load_val;
    next_addr = addr + 1'b1;
  end
`endif

  // Address register: load wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_addr;
    end else if (inc) begin
      addr <= next_addr;
    end
  end

endmodule

// File: rtl/sdp_rd_seq.sv
// Expands {cnt, base} commands into cnt read-address beats; wrap at DEPTH when SDP_RD_SEQ_WRAP_EN is defined.
// Latency: first beat valid one cycle after the command handshake; back-to-back bursts with no bubble.
// Backpressure: addr_data/addr_valid held while !addr_ready; cmd_ready only in IDLE or on the last beat's handshake.
module sdp_rd_seq
  import sdp_pkg::*;
#(
  parameter int W_ADDR = 16,
  parameter int W_CNT  = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [W_CNT+W_ADDR-1:0] cmd_data,
  output logic                    addr_valid,
  input  logic                    addr_ready,
  output logic [W_ADDR:0]         addr_data
);

  localparam int CNT_LSB = cmd_cnt_lsb(W_ADDR);
  localparam int EOT_POS = addr_eot_pos(W_ADDR);

  sdp_state_e        state;
  sdp_state_e        state_nxt;
  logic [W_CNT-1:0]  cmd_cnt;
  logic [W_ADDR-1:0] cmd_base;
  logic [W_CNT-1:0]  cnt_q;
  logic [W_CNT-1:0]  idx_q;
  logic [W_CNT-1:0]  idx_inc;
  logic [W_ADDR-1:0] addr_q;
  logic              eot_q;
  logic              beat_hs;
  logic              cmd_hs;
  logic              load;
  logic              adv;

  assign cmd_cnt  = cmd_data[CNT_LSB +: W_CNT];
  assign cmd_base = cmd_data[CMD_BASE_LSB +: W_ADDR];

  // BUSY is exactly "a beat is on the bus", so valid comes straight off the state flop.
  assign addr_valid = (state == BUSY);
  assign beat_hs    = addr_valid & addr_ready;
  assign cmd_ready  = (state == IDLE) | (beat_hs & eot_q);
  assign cmd_hs     = cmd_valid & cmd_ready;
  assign load       = cmd_hs & (cmd_cnt != '0);
  assign adv        = beat_hs & ~eot_q;
  assign idx_inc    = idx_q + 1'b1;

  assign addr_data[EOT_POS]                  = eot_q;
  assign addr_data[ADDR_ADDR_LSB +: W_ADDR]  = addr_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: zero-length commands are swallowed in IDLE; a command taken on the last beat chains straight into BUSY.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load) state_nxt = BUSY;
      end
      BUSY: begin
        if (beat_hs && eot_q) state_nxt = load ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping: eot is precomputed so it is registered alongside the address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      eot_q <= 1'b0;
    end else if (load) begin
      cnt_q <= cmd_cnt;
      idx_q <= '0;
      eot_q <= (cmd_cnt == W_CNT'(1));
    end else if (adv) begin
      idx_q <= idx_inc;
      eot_q <= (idx_inc == cnt_q - 1'b1);
    end
  end

  sdp_addr_cnt #(
    .W_ADDR (W_ADDR),
    .DEPTH  (DEPTH)
  ) u_addr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (cmd_base),
    .inc      (adv),
    .addr     (addr_q)
  );

endmodule

// File: tb/tb_sdp_rd_seq.sv
// Scoreboard bench for sdp_rd_seq: commands push expected beats, a negedge monitor pops and compares.
// Latency: checks first beat one cycle after each accepted non-empty command.
// Backpressure: addr_ready driven fixed, patterned or random; stalls must hold data.
module tb_sdp_rd_seq;

  localparam int W_ADDR = 16;
  localparam int W_CNT  = 16;
  localparam int DEPTH  = 1024;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [W_CNT+W_ADDR-1:0] cmd_data;
  logic                    addr_valid;
  logic                    addr_ready;
  logic [W_ADDR:0]         addr_data;

  typedef struct {
    logic [W_ADDR-1:0] addr;
    logic              eot;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    rdy_mode = 0;
  int    pat_idx  = 0;
  logic [6:0] rdy_pat = 7'b1101001;

  always #5 clk = ~clk;

  sdp_rd_seq #(
    .W_ADDR (W_ADDR),
    .W_CNT  (W_CNT),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_data  (addr_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference address: beat i of a burst from base.
  function automatic logic [W_ADDR-1:0] model_addr(input longint base, input longint i);
`ifdef SDP_RD_SEQ_WRAP_EN
    return W_ADDR'(((base % DEPTH) + i) % DEPTH);
`else
    return W_ADDR'((base + i) % (longint'(1) << W_ADDR));
`endif
  endfunction

  // addr_ready driver.
  initial begin
    addr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: addr_ready = 1'b1;
        1: addr_ready = ($urandom_range(0, 3) != 0);
        default: begin
          addr_ready = (pat_idx < 7) ? rdy_pat[pat_idx] : 1'b1;
          pat_idx++;
        end
      endcase
    end
  end

  // Monitor / scoreboard.
  logic              stall_prev = 1'b0;
  logic [W_ADDR:0]   held;
  logic              first_pending = 1'b0;
  logic [W_ADDR-1:0] first_addr;
  int                mon_cnt;
  longint            mon_base;
  beat_t             mon_b;
  beat_t             nb;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      stall_prev    = 1'b0;
      first_pending = 1'b0;
    end else begin
      if (first_pending) begin
        check("first_beat_valid", addr_valid, 1);
        check("first_beat_addr", addr_data[W_ADDR-1:0], first_addr);
        first_pending = 1'b0;
      end
      if (stall_prev) begin
        check("stall_valid_held", addr_valid, 1);
        check("stall_data_held", addr_data, held);
      end
      if (!addr_valid) begin
        check("idle_cmd_ready", cmd_ready, 1);
      end else if (exp_q.size() == 0) begin
        check("spurious_beat_valid", addr_valid, 0);
      end else begin
        check("busy_cmd_ready", cmd_ready, addr_ready && exp_q[0].eot);
        if (addr_ready) begin
          mon_b = exp_q.pop_front();
          check("beat_addr", addr_data[W_ADDR-1:0], mon_b.addr);
          check("beat_eot", addr_data[W_ADDR], mon_b.eot);
        end
      end
      stall_prev = addr_valid && !addr_ready;
      held       = addr_data;
      if (cmd_valid && cmd_ready) begin
        mon_cnt  = int'(cmd_data[W_ADDR +: W_CNT]);
        mon_base = longint'(cmd_data[W_ADDR-1:0]);
        for (int i = 0; i < mon_cnt; i++) begin
          nb.addr = model_addr(mon_base, i);
          nb.eot  = (i == mon_cnt - 1);
          exp_q.push_back(nb);
        end
        if (mon_cnt > 0) begin
          first_pending = 1'b1;
          first_addr    = model_addr(mon_base, 0);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  // Present one command and hold it until accepted; returns cycles waited.
  task automatic send_cmd(input int cnt, input int base, output int waited);
    int n;
    logic hs;
    n  = 0;
    hs = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = {W_CNT'(cnt), W_ADDR'(base)};
    do begin
      @(negedge clk);
      hs = cmd_ready;
      n++;
    end while (!hs && n < 500);
    if (!hs) check("cmd_accept_timeout", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    waited = n;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || addr_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending_beats", exp_q.size(), 0);
    check("drain_addr_valid", addr_valid, 0);
  endtask

  int w;
  int rc;
  int rb;

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = {W_CNT'(4), W_ADDR'(10)};
    #2;
    check("reset_addr_valid", addr_valid, 0);
    check("reset_addr_data", addr_data, 0);
    check("reset_cmd_ready", cmd_ready, 1);

    // Command waiting across reset release: must be taken on the first edge.
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check("first_edge_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    drain();

    // Back-to-back bursts.
    sync();
    send_cmd(3, 100, w);
    send_cmd(2, 200, w);
    drain();

    // Zero-length command.
    sync();
    send_cmd(0, 5, w);
    check("zero_cnt_accept_cycles", w, 1);
    repeat (3) begin
      @(negedge clk);
      check("zero_cnt_no_valid", addr_valid, 0);
    end
    drain();

    // Patterned backpressure.
    sync();
    pat_idx  = 0;
    rdy_mode = 2;
    send_cmd(4, 20, w);
    drain();
    rdy_mode = 0;

    // Crossing 1023.
    sync();
    send_cmd(3, 1023, w);
    drain();

    // Reset during the second beat.
    sync();
    send_cmd(8, 0, w);
    @(posedge clk);
    #2;
    check("pre_reset_valid", addr_valid, 1);
    rst = 1'b0;
    #1;
    check("async_reset_valid", addr_valid, 0);
    check("async_reset_data", addr_data, 0);
    check("async_reset_cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("post_reset_no_beat", addr_valid, 0);
    end
    sync();
    send_cmd(2, 50, w);
    drain();

    // Randomized traffic with random backpressure.
    sync();
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      rc = $urandom_range(0, 12);
      if ($urandom_range(0, 3) == 0) rb = 65535 - $urandom_range(0, 5);
      else                           rb = $urandom_range(0, 65535);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) sync();
      send_cmd(rc, rb, w);
    end
    rdy_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
